zone_max_gray: RTL and testbench

Per-zone peak-gray extractor between the LVDS receiver's RGB pixel stream and `buffer_360`. It divides the active frame into a 24×15 grid of 360 backlight zones and computes each pixel's gray value as max(R,G,B). It tracks the peak gray per zone and writes each zone's peak into `buffer_360` through its `buf_en`/`cnt_buf`/`gray` write port. The MiniLED driver consumes those values as per-zone dimming levels.

---
 rtl/zone_max_gray_if.sv | 34 +++
 rtl/zone_max_gray.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_zone_max_gray.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/zone_max_gray_if.sv
// -----------------------------------------------------------------------------
// zone_max_gray_if
//   Bundles the RGB pixel stream from the LVDS receiver with the zone-peak
//   write port that feeds buffer_360.
//
//   Pixel side  : de, vs, data_r, data_g, data_b   (source -> extractor)
//   Write side  : buf_en, cnt_buf[8:0], gray[7:0], frame_done
//                 (extractor -> buffer_360)
//
//   master : the pixel source / write sink (receiver + buffer side)
//   slave  : the zone_max_gray block
// -----------------------------------------------------------------------------
interface zone_max_gray_if;
  logic       de;
  logic       vs;
  logic [7:0] data_r;
  logic [7:0] data_g;
  logic [7:0] data_b;

  logic       buf_en;
  logic [8:0] cnt_buf;
  logic [7:0] gray;
  logic       frame_done;

  modport master (
    output de, vs, data_r, data_g, data_b,
    input  buf_en, cnt_buf, gray, frame_done
  );

  modport slave (
    input  de, vs, data_r, data_g, data_b,
    output buf_en, cnt_buf, gray, frame_done
  );
endinterface

// File: rtl/zone_max_gray.sv
// -----------------------------------------------------------------------------
// zone_max_gray
//   Per-zone peak-gray extractor. The active frame is split into a
//   ZONE_COLS x ZONE_ROWS grid; each pixel's gray is max(R,G,B) and the peak
//   per zone is written to buffer_360 one zone row at a time, as a burst of
//   ZONE_COLS consecutive writes after the last line of that zone row.
//
//   Ports
//     clk_x1 : pixel clock
//     rst_n  : asynchronous active-low reset
//     bus    : zone_max_gray_if.slave
//              in : de, vs, data_r/g/b
//              out: buf_en, cnt_buf (zone address), gray (zone peak),
//                   frame_done (one-cycle pulse after the last zone write)
// -----------------------------------------------------------------------------
module zone_max_gray #(
  parameter int ZONE_COLS = 24,
  parameter int ZONE_ROWS = 15,
  parameter int ZONE_W    = 80,   // must be >= ZONE_COLS + 2
  parameter int ZONE_H    = 72,
  parameter bit VS_POL    = 1'b1
) (
  input  logic            clk_x1,
  input  logic            rst_n,
  zone_max_gray_if.slave  bus
);

  localparam int SUB_W  = (ZONE_W > 1)    ? $clog2(ZONE_W)    : 1;
  localparam int COL_W  = $clog2(ZONE_COLS + 1);
  localparam int LINE_W = (ZONE_H > 1)    ? $clog2(ZONE_H)    : 1;
  localparam int ROW_W  = $clog2(ZONE_ROWS + 1);
  localparam int FCOL_W = (ZONE_COLS > 1) ? $clog2(ZONE_COLS) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(ZONE_W - 1);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(ZONE_COLS);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ZONE_H - 1);
  localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(ZONE_ROWS);
  localparam logic [FCOL_W-1:0] FCOL_LAST = FCOL_W'(ZONE_COLS - 1);
  localparam logic [8:0]        ADDR_LAST = 9'(ZONE_COLS * ZONE_ROWS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------------------------------------------------------------------
  // P1: input register, plus one extra vs tap for edge detection
  // ---------------------------------------------------------------------------
  logic       de_p1;
  logic       vs_p1;
  logic       vs_p1_d;
  logic [7:0] r_p1, g_p1, b_p1;

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of the others; = here would make stage order matter.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      de_p1   <= 1'b0;
      // Reset vs to its inactive level so leaving reset is not a frame start.
      vs_p1   <= ~VS_POL;
      vs_p1_d <= ~VS_POL;
      r_p1    <= '0;
      g_p1    <= '0;
      b_p1    <= '0;
    end else begin
      de_p1   <= bus.de;
      vs_p1   <= bus.vs;
      vs_p1_d <= vs_p1;
      r_p1    <= bus.data_r;
      g_p1    <= bus.data_g;
      b_p1    <= bus.data_b;
    end
  end

  logic frame_start;
  assign frame_start = (vs_p1 == VS_POL) && (vs_p1_d != VS_POL);

  // ---------------------------------------------------------------------------
  // P2: gray = max(R,G,B); de_p2_d gives the line-end edge
  // ---------------------------------------------------------------------------
  logic       de_p2;
  logic       de_p2_d;
  logic [7:0] gray_p2;

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      de_p2   <= 1'b0;
      de_p2_d <= 1'b0;
      gray_p2 <= '0;
    end else begin
      de_p2   <= de_p1;
      de_p2_d <= de_p2;
      gray_p2 <= max8(max8(r_p1, g_p1), b_p1);
    end
  end

  // ---------------------------------------------------------------------------
  // Position tracking. The x position is held as (col, sub_x) so the zone
  // column falls out of a sub-counter instead of a divider. col saturates at
  // ZONE_COLS, which marks pixels beyond the active grid.
  // ---------------------------------------------------------------------------
  logic [SUB_W-1:0]  sub_x;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line_in_row;
  logic [ROW_W-1:0]  zone_row;
  logic [7:0]        cur_max;
  logic [7:0]        row_max [ZONE_COLS];

  logic       de_fall;
  logic       row_active;
  logic       col_active;
  logic       pix_active;
  logic       col_last;
  logic [7:0] pix_max;
  logic       flush_trig;

  assign de_fall    = de_p2_d && !de_p2;
  assign row_active = (zone_row < ROW_END);
  assign col_active = (col < COL_END);
  assign pix_active = de_p2 && row_active && col_active;
  assign col_last   = (sub_x == SUB_LAST);
  assign pix_max    = max8(cur_max, gray_p2);
  assign flush_trig = de_fall && row_active && (line_in_row == LINE_LAST);

  // Column merge: either the last pixel of a full zone column, or the partial
  // column left behind when de falls early (merged on the fall cycle).
  logic       merge_en;
  logic [7:0] merge_val;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    merge_en  = 1'b0;
    merge_val = cur_max;
    if (pix_active && col_last) begin
      merge_en  = 1'b1;
      merge_val = pix_max;
    end else if (de_fall && row_active && col_active) begin
      merge_en  = 1'b1;
      merge_val = cur_max;
    end
  end

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      sub_x       <= '0;
      col         <= '0;
      cur_max     <= '0;
      line_in_row <= '0;
      zone_row    <= '0;
    end else if (frame_start) begin
      sub_x       <= '0;
      col         <= '0;
      cur_max     <= '0;
      line_in_row <= '0;
      zone_row    <= '0;
    end else begin
      if (de_p2) begin
        if (pix_active) begin
          if (col_last) begin
            sub_x   <= '0;
            col     <= col + 1'b1;
            cur_max <= '0;
          end else begin
            sub_x   <= sub_x + 1'b1;
            cur_max <= pix_max;
          end
        end
      end else begin
        sub_x   <= '0;
        col     <= '0;
        cur_max <= '0;
      end

      if (de_fall && row_active) begin
        if (line_in_row == LINE_LAST) begin
          line_in_row <= '0;
          zone_row    <= zone_row + 1'b1;
        end else begin
          line_in_row <= line_in_row + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              wr_fire;
  logic [FCOL_W-1:0] flush_col;
  logic [7:0]        flush_val;

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_fire = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (flush_trig) state_d = ST_FLUSH;
      ST_FLUSH: begin
        wr_fire = 1'b1;
        if (flush_col == FCOL_LAST) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    // A new frame aborts a burst in flight; buf_en drops on the next edge.
    if (frame_start) begin
      state_d = ST_IDLE;
      wr_fire = 1'b0;
    end
  end

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      flush_col <= '0;
    end else if (frame_start) begin
      flush_col <= '0;
    end else if (wr_fire) begin
      flush_col <= (flush_col == FCOL_LAST) ? '0 : flush_col + 1'b1;
    end
  end

  always_comb begin
    flush_val = '0;
    for (int c = 0; c < ZONE_COLS; c++) begin
      if (flush_col == FCOL_W'(c)) flush_val = row_max[c];
    end
  end

  // NOTE: row_max is a handful of flops, not a RAM, so it takes the async
  // reset like any other register; a RAM-mapped store would be left unreset.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < ZONE_COLS; c++) row_max[c] <= '0;
    end else if (frame_start) begin
      for (int c = 0; c < ZONE_COLS; c++) row_max[c] <= '0;
    end else begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        if (merge_en && (col == COL_W'(c))) begin
          // If this entry is being flushed in the same cycle, its old value
          // belongs to the previous zone row and must not leak into the new one.
          row_max[c] <= (wr_fire && (flush_col == FCOL_W'(c)))
                        ? merge_val : max8(row_max[c], merge_val);
        end else if (wr_fire && (flush_col == FCOL_W'(c))) begin
          row_max[c] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port. Addresses ascend through the frame, so a single
  // running address replaces row*ZONE_COLS+col.
  // ---------------------------------------------------------------------------
  logic       buf_en_q;
  logic [8:0] cnt_buf_q;
  logic [7:0] gray_q;
  logic       frame_done_q;
  logic [8:0] wr_addr;

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      buf_en_q     <= 1'b0;
      cnt_buf_q    <= '0;
      gray_q       <= '0;
      frame_done_q <= 1'b0;
      wr_addr      <= '0;
    end else if (frame_start) begin
      buf_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr      <= '0;
    end else begin
      buf_en_q     <= wr_fire;
      frame_done_q <= buf_en_q && (cnt_buf_q == ADDR_LAST);
      if (wr_fire) begin
        cnt_buf_q <= wr_addr;
        gray_q    <= flush_val;
        wr_addr   <= wr_addr + 9'd1;
      end
    end
  end

  assign bus.buf_en     = buf_en_q;
  assign bus.cnt_buf    = cnt_buf_q;
  assign bus.gray       = gray_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_zone_max_gray.sv
// -----------------------------------------------------------------------------
// tb_zone_max_gray
//   Directed bench for zone_max_gray on a reduced 4x3 grid of 8x4-pixel zones
//   (32x12 active pixels, 12 zone addresses) so every scenario runs in a few
//   hundred cycles. Writes and frame_done pulses are logged on the falling
//   edge and compared with hand-computed expected zone values.
// -----------------------------------------------------------------------------
module tb_zone_max_gray;

  localparam int C  = 4;
  localparam int R  = 3;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NZ = C * R;
  localparam int FW = C * W;
  localparam int FH = R * H;

  localparam int K_UNI = 0;  // every pixel R=G=B=level
  localparam int K_DOT = 1;  // one R=FF pixel at (13,7) -> zone row 1, col 1
  localparam int K_MIX = 2;  // one pixel R=10 G=90 B=80 at (2,1) -> zone 0
  localparam int K_OOR = 3;  // bright pixels only outside the active grid

  logic clk_x1 = 1'b0;
  logic rst_n  = 1'b0;

  zone_max_gray_if bus();

  zone_max_gray #(
    .ZONE_COLS(C), .ZONE_ROWS(R), .ZONE_W(W), .ZONE_H(H), .VS_POL(1'b1)
  ) dut (
    .clk_x1 (clk_x1),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_x1 = ~clk_x1;

  int cyc = 0;
  always @(posedge clk_x1) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write / frame_done log
  int wr_addr_q[$];
  int wr_gray_q[$];
  int wr_cyc_q[$];
  int fd_cyc_q[$];
  int fall_cyc[64];
  int exp_gray[NZ];

  always @(negedge clk_x1) begin
    if (rst_n) begin
      if (bus.buf_en) begin
        wr_addr_q.push_back(int'(bus.cnt_buf));
        wr_gray_q.push_back(int'(bus.gray));
        wr_cyc_q.push_back(cyc);
      end
      if (bus.frame_done) fd_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [23:0] pix(input int kind, input int level, input int x, input int y);
    logic [7:0] lv;
    lv = level[7:0];
    case (kind)
      K_UNI:   return {lv, lv, lv};
      K_DOT:   return (x == 13 && y == 7) ? 24'hFF0000 : 24'h0;
      K_MIX:   return (x == 2 && y == 1)  ? 24'h109080 : 24'h0;
      K_OOR:   return (y == FH + 1 || x == FW + 2) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // vs pulse, 4 clocks of vertical blanking, then n_lines lines of `width`
  // pixels with 3 clocks of horizontal blanking. Inputs change on negedge.
  task automatic drive_frame(input int n_lines, input int width, input int kind, input int level);
    @(negedge clk_x1);
    bus.vs = 1'b1;
    repeat (2) @(negedge clk_x1);
    bus.vs = 1'b0;
    repeat (4) @(negedge clk_x1);
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < width; x++) begin
        bus.de = 1'b1;
        {bus.data_r, bus.data_g, bus.data_b} = pix(kind, level, x, y);
        @(negedge clk_x1);
      end
      bus.de = 1'b0;
      {bus.data_r, bus.data_g, bus.data_b} = 24'h0;
      fall_cyc[y] = cyc;
      repeat (3) @(negedge clk_x1);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_gray_q.delete();
    wr_cyc_q.delete();
    fd_cyc_q.delete();
  endtask

  task automatic set_exp(input int level);
    for (int i = 0; i < NZ; i++) exp_gray[i] = level;
  endtask

  task automatic check_writes(input string tag, input int n_exp, input int n_fd);
    check({tag, " write_count"}, wr_addr_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wr_addr_q[i], i);
      check($sformatf("%s gray[%0d]", tag, i), wr_gray_q[i], exp_gray[i]);
      if (i % C != 0)
        check($sformatf("%s burst_contig[%0d]", tag, i), wr_cyc_q[i], wr_cyc_q[i-1] + 1);
    end
    check({tag, " frame_done_count"}, fd_cyc_q.size(), n_fd);
    if (n_fd == 1 && fd_cyc_q.size() == 1 && wr_cyc_q.size() > 0)
      check({tag, " frame_done_timing"}, fd_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
  endtask

  task automatic settle();
    repeat (30) @(negedge clk_x1);
  endtask

  initial begin
    bit found;
    bus.de = 1'b0;
    bus.vs = 1'b0;
    {bus.data_r, bus.data_g, bus.data_b} = 24'h0;

    // Reset state
    repeat (3) @(negedge clk_x1);
    check("reset buf_en",     bus.buf_en,     1'b0);
    check("reset cnt_buf",    bus.cnt_buf,    9'd0);
    check("reset gray",       bus.gray,       8'd0);
    check("reset frame_done", bus.frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_x1);
    check("idle buf_en", bus.buf_en, 1'b0);

    // Uniform frame
    clear_log();
    drive_frame(FH, FW, K_UNI, 8'h40);
    settle();
    set_exp(8'h40);
    check_writes("uniform", NZ, 1);

    // Single bright pixel, plus flush latency from line H-1's de fall
    clear_log();
    drive_frame(FH, FW, K_DOT, 0);
    settle();
    set_exp(0);
    exp_gray[1*C + 1] = 8'hFF;
    check_writes("dot", NZ, 1);
    if (wr_cyc_q.size() > 0) check("dot flush_latency", wr_cyc_q[0] - fall_cyc[H-1], 4);
    else                     check("dot flush_latency", 0, 4);

    // Gray = max of channels, then clear-on-flush with a black frame
    clear_log();
    drive_frame(FH, FW, K_MIX, 0);
    settle();
    set_exp(0);
    exp_gray[0] = 8'h90;
    check_writes("mix", NZ, 1);
    clear_log();
    drive_frame(FH, FW, K_UNI, 0);
    settle();
    set_exp(0);
    check_writes("black", NZ, 1);

    // Over-long lines and extra lines beyond the grid are ignored
    clear_log();
    drive_frame(FH + 2, FW + 4, K_OOR, 0);
    settle();
    set_exp(0);
    check_writes("oor", NZ, 1);

    // vs mid-frame: only zone row 0 completes; the next frame starts clean
    clear_log();
    drive_frame(H + 2, FW, K_UNI, 8'h70);
    settle();
    set_exp(8'h70);
    check_writes("abort", C, 0);
    clear_log();
    drive_frame(FH, FW, K_UNI, 8'h20);
    settle();
    set_exp(8'h20);
    check_writes("after_abort", NZ, 1);

    // Reset during the zone-row-1 burst (address C+2)
    clear_log();
    drive_frame(2 * H, FW, K_UNI, 8'h30);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.buf_en && bus.cnt_buf == 9'(C + 2)) found = 1'b1;
      else @(negedge clk_x1);
    end
    check("rst_mid wait_write", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid buf_en",     bus.buf_en,     1'b0);
    check("rst_mid cnt_buf",    bus.cnt_buf,    9'd0);
    check("rst_mid gray",       bus.gray,       8'd0);
    check("rst_mid frame_done", bus.frame_done, 1'b0);
    repeat (3) @(negedge clk_x1);
    rst_n = 1'b1;
    clear_log();
    drive_frame(FH, FW, K_UNI, 8'h50);
    settle();
    set_exp(8'h50);
    check_writes("after_reset", NZ, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1);
  end

endmodule
